// File: rtl/interval_timer_if.sv
// Control/status bundle between an interval_timer instance and its controller.
// The controller drives the request side; the timer drives interrupt, busy and count.
interface interval_timer_if #(
    parameter int unsigned COUNT_WIDTH = 16
);
    logic                   start_in;
    logic                   stop_in;
    logic                   hold_in;
    logic                   reload_in;
    logic [COUNT_WIDTH-1:0] period_in;
    logic                   int_out;
    logic                   busy_out;
    logic [COUNT_WIDTH-1:0] count_out;

    modport master (
        output start_in,
        output stop_in,
        output hold_in,
        output reload_in,
        output period_in,
        input  int_out,
        input  busy_out,
        input  count_out
    );

    modport slave (
        input  start_in,
        input  stop_in,
        input  hold_in,
        input  reload_in,
        input  period_in,
        output int_out,
        output busy_out,
        output count_out
    );
endinterface

// File: rtl/interval_timer.sv
// Programmable interval timer: a prescaler generates ticks, a down-counter counts a
// programmed number of ticks and raises a one-cycle interrupt, with optional auto-reload.
module interval_timer #(
    parameter int unsigned COUNT_WIDTH    = 16,
    parameter int unsigned PRESCALE_DIV   = 12000,
    parameter int unsigned PRESCALE_WIDTH = 14
) (
    input  logic               clock_in,
    input  logic               reset_in,
    interval_timer_if.slave    bus
);

    typedef enum logic {StIdle, StRun} state_e;

    localparam logic [PRESCALE_WIDTH-1:0] PreLast = PRESCALE_WIDTH'(PRESCALE_DIV - 1);
    localparam logic [COUNT_WIDTH-1:0]    CntOne  = COUNT_WIDTH'(1);

    state_e                    state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] pre_q, pre_d;
    logic [COUNT_WIDTH-1:0]    count_q, count_d;
    logic [COUNT_WIDTH-1:0]    period_q, period_d;
    logic                      int_q, int_d;

    logic tick;
    logic expire;

    assign tick   = (state_q == StRun) && !bus.hold_in && (pre_q == PreLast);
    assign expire = tick && (count_q == CntOne);

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q  <= StIdle;
            pre_q    <= '0;
            count_q  <= '0;
            period_q <= '0;
            int_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            count_q  <= count_d;
            period_q <= period_d;
            int_q    <= int_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        count_d  = count_q;
        period_d = period_q;
        int_d    = 1'b0;

        if (bus.stop_in) begin
            state_d = StIdle;
            pre_d   = '0;
            count_d = '0;
        end else if (bus.start_in) begin
            // A period that completes on the same edge as a restart still reports.
            int_d = expire;
            pre_d = '0;
            if (bus.period_in != '0) begin
                period_d = bus.period_in;
                count_d  = bus.period_in;
                state_d  = StRun;
            end else begin
                int_d   = 1'b1;
                count_d = '0;
                state_d = StIdle;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    pre_d = '0;
                end
                StRun: begin
                    if (!bus.hold_in) begin
                        if (tick) begin
                            pre_d = '0;
                            if (expire) begin
                                int_d = 1'b1;
                                if (bus.reload_in) begin
                                    count_d = period_q;
                                end else begin
                                    count_d = '0;
                                    state_d = StIdle;
                                end
                            end else if (count_q != '0) begin
                                count_d = count_q - CntOne;
                            end
                        end else begin
                            pre_d = pre_q + PRESCALE_WIDTH'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign bus.int_out   = int_q;
    assign bus.busy_out  = (state_q == StRun);
    assign bus.count_out = count_q;

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer: directed scenarios plus a random phase,
// compared against an elapsed-cycle model of the timer.
module tb_interval_timer;

    localparam int unsigned CW  = 8;
    localparam int unsigned DIV = 4;
    localparam int unsigned PW  = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;

    // Model state: running flag, period in ticks, active cycles since (re)start.
    int   m_run;
    int   m_n;
    int   m_el;
    int   m_int;

    interval_timer_if #(.COUNT_WIDTH(CW)) ifc ();

    interval_timer #(
        .COUNT_WIDTH   (CW),
        .PRESCALE_DIV  (DIV),
        .PRESCALE_WIDTH(PW)
    ) dut (
        .clock_in(clk),
        .reset_in(rst_n),
        .bus     (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_run = 0;
        m_n   = 0;
        m_el  = 0;
        m_int = 0;
    endtask

    task automatic check_model(input string tag);
        int exp_cnt;
        exp_cnt = (m_run != 0) ? (m_n - m_el / DIV) : 0;
        chk({tag, ".int"},   32'(ifc.int_out),   32'(m_int));
        chk({tag, ".busy"},  32'(ifc.busy_out),  32'(m_run));
        chk({tag, ".count"}, 32'(ifc.count_out), 32'(exp_cnt));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check.
    task automatic step(input logic st, input logic sp, input logic hd, input logic rl,
                        input logic [CW-1:0] per, input string tag);
        int int_n;
        bit exp_now;
        ifc.start_in  = st;
        ifc.stop_in   = sp;
        ifc.hold_in   = hd;
        ifc.reload_in = rl;
        ifc.period_in = per;
        @(posedge clk);
        cyc++;
        int_n = 0;
        if (sp) begin
            m_run = 0;
            m_el  = 0;
        end else begin
            exp_now = (m_run != 0) && !hd && (m_el + 1 == m_n * DIV);
            if (st) begin
                if (exp_now) int_n = 1;
                if (per != 0) begin
                    m_run = 1;
                    m_n   = int'(per);
                    m_el  = 0;
                end else begin
                    int_n = 1;
                    m_run = 0;
                end
            end else if ((m_run != 0) && !hd) begin
                m_el++;
                if (m_el == m_n * DIV) begin
                    int_n = 1;
                    if (rl) m_el = 0;
                    else m_run = 0;
                end
            end
        end
        m_int = int_n;
        #1;
        check_model(tag);
    endtask

    task automatic idle(input int n, input logic rl, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, rl, '0, tag);
    endtask

    // Step idle cycles until int_out is seen; returns the cycle number, or -1 on timeout.
    task automatic wait_int(input int limit, input logic rl, input string tag, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            step(1'b0, 1'b0, 1'b0, rl, '0, tag);
            if (ifc.int_out === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk({tag, ".timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int t0;
        int at;
        int prev;
        checks = 0;
        errors = 0;
        cyc    = 0;
        model_reset();
        rst_n         = 1'b0;
        ifc.start_in  = 1'b0;
        ifc.stop_in   = 1'b0;
        ifc.hold_in   = 1'b0;
        ifc.reload_in = 1'b0;
        ifc.period_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.int",   32'(ifc.int_out),   32'd0);
        chk("reset.busy",  32'(ifc.busy_out),  32'd0);
        chk("reset.count", 32'(ifc.count_out), 32'd0);
        rst_n = 1'b1;

        // One-shot, period 3: pulse 12 cycles after start, count 3,2,1,0.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'd3, "oneshot.start");
        t0 = cyc;
        chk("oneshot.count0", 32'(ifc.count_out), 32'd3);
        wait_int(40, 1'b0, "oneshot", at);
        chk("oneshot.latency", 32'(at - t0), 32'd12);
        chk("oneshot.busy_fall", 32'(ifc.busy_out), 32'd0);
        idle(6, 1'b0, "oneshot.after");

        // Auto-reload, period 2: pulses every 8 cycles, one more after reload drops.
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'd2, "reload.start");
        t0 = cyc;
        wait_int(40, 1'b1, "reload.p1", at);
        chk("reload.first", 32'(at - t0), 32'd8);
        prev = at;
        wait_int(40, 1'b1, "reload.p2", at);
        chk("reload.gap", 32'(at - prev), 32'd8);
        prev = at;
        wait_int(40, 1'b0, "reload.last", at);
        chk("reload.last_gap", 32'(at - prev), 32'd8);
        chk("reload.idle", 32'(ifc.busy_out), 32'd0);
        idle(12, 1'b0, "reload.quiet");

        // Stop at cycle 5 of a period-3 run.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'd3, "stop.start");
        idle(4, 1'b0, "stop.run");
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, "stop.stop");
        chk("stop.busy", 32'(ifc.busy_out), 32'd0);
        chk("stop.count", 32'(ifc.count_out), 32'd0);
        idle(16, 1'b0, "stop.quiet");

        // Restart at cycle 6 with period 5.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'd3, "restart.first");
        idle(5, 1'b0, "restart.run");
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'd5, "restart.second");
        t0 = cyc;
        wait_int(60, 1'b0, "restart", at);
        chk("restart.latency", 32'(at - t0), 32'd20);

        // Hold for 7 cycles mid-run with period 2.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'd2, "hold.start");
        t0 = cyc;
        idle(3, 1'b0, "hold.run");
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 1'b0, '0, "hold.held");
        wait_int(40, 1'b0, "hold", at);
        chk("hold.latency", 32'(at - t0), 32'd15);

        // Zero period: immediate pulse, never busy.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "zero.start");
        chk("zero.int", 32'(ifc.int_out), 32'd1);
        chk("zero.busy", 32'(ifc.busy_out), 32'd0);
        idle(3, 1'b0, "zero.after");

        // Asynchronous reset between edges during a run.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'd3, "arst.start");
        idle(5, 1'b0, "arst.run");
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.int",   32'(ifc.int_out),   32'd0);
        chk("arst.busy",  32'(ifc.busy_out),  32'd0);
        chk("arst.count", 32'(ifc.count_out), 32'd0);
        model_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        idle(16, 1'b0, "arst.quiet");
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'd1, "arst.p1");
        t0 = cyc;
        wait_int(20, 1'b0, "arst.p1", at);
        chk("arst.p1_latency", 32'(at - t0), 32'd4);

        // Start coincident with expiry.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'd1, "coinc.start");
        idle(3, 1'b0, "coinc.run");
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'd2, "coinc.restart");
        chk("coinc.int", 32'(ifc.int_out), 32'd1);
        chk("coinc.busy", 32'(ifc.busy_out), 32'd1);
        t0 = cyc;
        wait_int(40, 1'b0, "coinc.second", at);
        chk("coinc.gap", 32'(at - t0), 32'd8);

        // Random phase against the model.
        for (int i = 0; i < 1500; i++) begin
            logic st;
            logic sp;
            logic hd;
            logic rl;
            logic [CW-1:0] per;
            st  = ($urandom_range(0, 19) == 0);
            sp  = ($urandom_range(0, 39) == 0);
            hd  = ($urandom_range(0, 5) == 0);
            rl  = ($urandom_range(0, 2) != 0);
            per = CW'($urandom_range(0, 5));
            step(st, sp, hd, rl, per, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
